subleq_sequencer: RTL and testbench
===================================

Name: subleq_sequencer

Overview:
- Instruction sequencer for the SUBLEQ core.
- Owns the PC and the three-word instruction fetch, and drives the memory port.
- Sits directly upstream of the A operand register: it loads mem[A] into that register through a_set/a_data and reads the stored value back on a_value.
- In the execute step it writes mem[B] - A back to memory and takes the branch when the result is less than or equal to zero.

Parameters:
- WORD_SIZE, 16, width of data words, addresses and PC.

Ports:
- clk  input  1  clock, rising edge.
- areset  input  1  reset, synchronous, active-high.
- run  input  1  leave IDLE and start executing at the current PC.
- halted  output  1  high in HALT state.
- mem_req  output  1  memory transaction request.
- mem_we  output  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  output  WORD_SIZE  transaction address.
- mem_wdata  output  WORD_SIZE  write data.
- mem_rdata  input  WORD_SIZE  read data; valid in the cycle mem_ack is high.
- mem_ack  input  1  transaction completes in this cycle.
- a_set  output  1  load strobe to the A register.
- a_data  output  WORD_SIZE  value to load into the A register.
- a_value  input  WORD_SIZE  current contents of the A register.
- pc  output  WORD_SIZE  current instruction address.

Behaviour:
- Reset (areset high at a clk edge):
  - state = IDLE; pc = 0; internal a_ptr, b_ptr, c_ptr and mb = 0.
  - mem_req, mem_we, a_set, halted = 0; mem_addr, mem_wdata, a_data = 0.
  - Reset has priority over all other events and aborts any in-flight transaction; mem_req is low in the cycle after reset.
- Handshake:
  - In a memory state, mem_req = 1, and mem_addr, mem_we and mem_wdata are held stable until a cycle where mem_ack = 1.
  - In the ack cycle the transaction completes, mem_rdata is sampled, and the state advances on the next edge.
  - Back-to-back requests are allowed. mem_ack while mem_req = 0 is ignored.
- State sequence (each memory state waits for mem_ack):
  - IDLE: no request; go to RD_A when run = 1.
  - RD_A: read at pc; a_ptr <= rdata.
  - RD_MA: read at a_ptr. In the ack cycle a_set = 1 and a_data = mem_rdata (combinational), so the A register loads on that edge. a_set is exactly one cycle per instruction.
  - RD_B: read at pc+1; b_ptr <= rdata.
  - RD_MB: read at b_ptr; mb <= rdata.
  - RD_C: read at pc+2; c_ptr <= rdata.
  - WR_B: write at b_ptr with mem_we = 1 and mem_wdata = mb - a_value (modulo 2^WORD_SIZE). On ack, register leq = (result == 0) or result[WORD_SIZE-1].
  - NEXT (one cycle, no request):
    - If leq and c_ptr == all-ones: go to HALT, pc unchanged.
    - Else if leq: pc <= c_ptr, then RD_A.
    - Else: pc <= pc+3, then RD_A.
  - HALT: halted = 1, no requests, run ignored. Only areset leaves HALT.
- Arithmetic:
  - pc+1, pc+2 and pc+3 wrap modulo 2^WORD_SIZE.
  - Fetch from 0xFFFE uses addresses 0xFFFE, 0xFFFF, 0x0000.
- run is sampled only in IDLE. Deasserting run mid-instruction has no effect; the sequencer free-runs until HALT or reset.
- Minimum instruction time with zero-wait ack is 7 cycles (6 transactions + NEXT).

Test Plan (WORD_SIZE = 16, zero-wait memory model unless stated):
1. Positive result: mem[0..2] = 10, 11, 9; mem[10] = 5; mem[11] = 7 -> a_set pulses once with a_data = 5; write addr 11 data 0x0002; pc = 3; 7 cycles from RD_A.
2. Zero result branches: mem[10] = 7, mem[11] = 7 -> write 0x0000; pc = 9.
3. Negative result branches: mem[10] = 8, mem[11] = 3 -> write 0xFFFB; pc = 9.
4. Halt: C = 0xFFFF with mem[A] = mem[B] -> halted = 1, pc = 0, mem_req stays low for 20 cycles; toggling run has no effect; areset returns to IDLE with halted = 0.
5. Wait states and wrap: ack delayed 3 cycles per transaction, pc preset to 0xFFFE via program flow -> addr/we/wdata stable while waiting; fetch addresses 0xFFFE, 0xFFFF, 0x0000; non-branch next pc = 0x0001; a_set still a single pulse.
6. Reset mid-write: areset asserted in WR_B before ack -> mem_req = 0 the next cycle, pc = 0, state IDLE, and no further requests until run.

Source files
------------

// File: rtl/subleq_sequencer.sv
`default_nettype none
// ============================================================================
// subleq_sequencer : PC, three-word fetch and execute control for the SUBLEQ core
// Revision 1.0
// ============================================================================
module subleq_sequencer #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 run,
  output logic                 halted,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ack,
  output logic                 a_set,
  output logic [WORD_SIZE-1:0] a_data,
  input  logic [WORD_SIZE-1:0] a_value,
  output logic [WORD_SIZE-1:0] pc
);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    RD_A  = 4'd1,
    RD_MA = 4'd2,
    RD_B  = 4'd3,
    RD_MB = 4'd4,
    RD_C  = 4'd5,
    WR_B  = 4'd6,
    NEXT  = 4'd7,
    HALT  = 4'd8
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [WORD_SIZE-1:0] a_ptr;
  logic [WORD_SIZE-1:0] b_ptr;
  logic [WORD_SIZE-1:0] c_ptr;
  logic [WORD_SIZE-1:0] mb;
  logic                 leq;
  logic [WORD_SIZE-1:0] result;
  logic                 result_leq;
  logic                 c_all_ones;

  assign result     = mb - a_value;
  assign result_leq = (result == '0) | result[WORD_SIZE-1];
  assign c_all_ones = &c_ptr;

  always_ff @(posedge clk) begin
    if (areset) begin
      state <= IDLE;
      pc    <= '0;
      a_ptr <= '0;
      b_ptr <= '0;
      c_ptr <= '0;
      mb    <= '0;
      leq   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        RD_A:  if (mem_ack) a_ptr <= mem_rdata;
        RD_B:  if (mem_ack) b_ptr <= mem_rdata;
        RD_MB: if (mem_ack) mb    <= mem_rdata;
        RD_C:  if (mem_ack) c_ptr <= mem_rdata;
        WR_B:  if (mem_ack) leq   <= result_leq;
        NEXT: begin
          // A taken branch to all-ones halts with pc left on the halting instruction
          if (!leq)             pc <= pc + WORD_SIZE'(3);
          else if (!c_all_ones) pc <= c_ptr;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    a_set     = 1'b0;
    a_data    = '0;
    halted    = 1'b0;
    case (state)
      IDLE: if (run) state_nx = RD_A;
      RD_A: begin
        mem_req  = 1'b1;
        mem_addr = pc;
        if (mem_ack) state_nx = RD_MA;
      end
      RD_MA: begin
        mem_req  = 1'b1;
        mem_addr = a_ptr;
        if (mem_ack) begin
          a_set    = 1'b1;
          a_data   = mem_rdata;
          state_nx = RD_B;
        end
      end
      RD_B: begin
        mem_req  = 1'b1;
        mem_addr = pc + WORD_SIZE'(1);
        if (mem_ack) state_nx = RD_MB;
      end
      RD_MB: begin
        mem_req  = 1'b1;
        mem_addr = b_ptr;
        if (mem_ack) state_nx = RD_C;
      end
      RD_C: begin
        mem_req  = 1'b1;
        mem_addr = pc + WORD_SIZE'(2);
        if (mem_ack) state_nx = WR_B;
      end
      WR_B: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = b_ptr;
        mem_wdata = result;
        if (mem_ack) state_nx = NEXT;
      end
      NEXT:    state_nx = (leq && c_all_ones) ? HALT : RD_A;
      HALT:    halted = 1'b1;
      default: state_nx = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_subleq_sequencer.sv
`default_nettype none
// ============================================================================
// tb_subleq_sequencer : directed vectors for subleq_sequencer with a memory
// model of configurable ack latency and a behavioural A register. Revision 1.0
// ============================================================================
module tb_subleq_sequencer;

  logic        clk = 1'b0;
  logic        areset = 1'b0;
  logic        run = 1'b0;
  logic        halted;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        a_set;
  logic [15:0] a_data;
  logic [15:0] a_reg = 16'h0;
  logic [15:0] pc;

  logic [15:0] mem [0:65535];
  logic        prog_we = 1'b0;
  logic [15:0] prog_addr = 16'h0;
  logic [15:0] prog_data = 16'h0;
  logic        clr = 1'b0;
  int          lat = 0;
  int          wcnt = 0;

  // monitor state
  int          req_cnt = 0;
  int          aset_cnt = 0;
  int          wr_cnt = 0;
  int          stab_err = 0;
  logic [15:0] last_adata = 16'h0;
  logic [15:0] last_waddr = 16'h0;
  logic [15:0] last_wdata = 16'h0;
  logic [15:0] rd_log[$];
  logic        p_wait = 1'b0;
  logic [15:0] p_addr = 16'h0;
  logic [15:0] p_wdata = 16'h0;
  logic        p_we = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  subleq_sequencer #(.WORD_SIZE(16)) dut (
    .clk       (clk),
    .areset    (areset),
    .run       (run),
    .halted    (halted),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .a_set     (a_set),
    .a_data    (a_data),
    .a_value   (a_reg),
    .pc        (pc)
  );

  always #5 clk = ~clk;

  assign mem_ack   = mem_req && (wcnt >= lat);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (prog_we)
      mem[prog_addr] <= prog_data;
    else if (!areset && mem_req && mem_we && mem_ack)
      mem[mem_addr] <= mem_wdata;
    if (areset || !mem_req || mem_ack) wcnt <= 0;
    else                               wcnt <= wcnt + 1;
    if (!areset && a_set) a_reg <= a_data;
    p_wait  <= mem_req && !mem_ack && !areset;
    p_addr  <= mem_addr;
    p_we    <= mem_we;
    p_wdata <= mem_wdata;
    if (clr) begin
      req_cnt  <= 0;
      aset_cnt <= 0;
      wr_cnt   <= 0;
      stab_err <= 0;
      rd_log.delete();
    end else if (!areset) begin
      if (mem_req) req_cnt <= req_cnt + 1;
      if (a_set) begin
        aset_cnt   <= aset_cnt + 1;
        last_adata <= a_data;
      end
      if (mem_req && mem_we && mem_ack) begin
        wr_cnt     <= wr_cnt + 1;
        last_waddr <= mem_addr;
        last_wdata <= mem_wdata;
      end
      if (mem_req && !mem_we && mem_ack) rd_log.push_back(mem_addr);
      if (p_wait && mem_req &&
          (mem_addr != p_addr || mem_we != p_we || mem_wdata != p_wdata))
        stab_err <= stab_err + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); areset = 1'b1; run = 1'b0;
    @(negedge clk); areset = 1'b0;
  endtask

  task automatic clear_mon();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  // Counts rising edges until pc moves away from its value at entry.
  task automatic wait_pc_change(input int maxc, output int cyc);
    logic [15:0] start;
    start = pc;
    cyc = 0;
    while (cyc < maxc) begin
      @(posedge clk); #1;
      cyc++;
      if (pc != start) break;
    end
  endtask

  task automatic load_prog(input logic [15:0] c, input logic [15:0] ma, input logic [15:0] mbv);
    poke(16'd0, 16'd10);
    poke(16'd1, 16'd11);
    poke(16'd2, c);
    poke(16'd10, ma);
    poke(16'd11, mbv);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int found;

    // reset state
    do_reset();
    #1;
    check("rst_req", mem_req, 0);
    check("rst_halted", halted, 0);
    check("rst_pc", pc, 0);
    check("rst_aset", a_set, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_adata", a_data, 0);

    // 1: positive result, 1 idle->RD_A edge + 7 instruction cycles
    lat = 0;
    load_prog(16'd9, 16'd5, 16'd7);
    clear_mon();
    @(negedge clk); run = 1'b1;
    wait_pc_change(40, cyc);
    check("t1_cycles", cyc, 8);
    check("t1_pc", pc, 16'd3);
    check("t1_aset_cnt", aset_cnt, 1);
    check("t1_adata", last_adata, 16'd5);
    check("t1_waddr", last_waddr, 16'd11);
    check("t1_wdata", last_wdata, 16'h0002);
    check("t1_mem11", mem[11], 16'h0002);

    // 2: zero result branches
    do_reset();
    load_prog(16'd9, 16'd7, 16'd7);
    clear_mon();
    @(negedge clk); run = 1'b1;
    wait_pc_change(40, cyc);
    check("t2_pc", pc, 16'd9);
    check("t2_wdata", last_wdata, 16'h0000);
    check("t2_wr_cnt", wr_cnt, 1);

    // 3: negative result branches
    do_reset();
    load_prog(16'd9, 16'd8, 16'd3);
    clear_mon();
    @(negedge clk); run = 1'b1;
    wait_pc_change(40, cyc);
    check("t3_pc", pc, 16'd9);
    check("t3_wdata", last_wdata, 16'hFFFB);

    // 4: halt on branch to all-ones
    do_reset();
    load_prog(16'hFFFF, 16'd4, 16'd4);
    clear_mon();
    @(negedge clk); run = 1'b1;
    cyc = 0;
    while (cyc < 50 && !halted) begin
      @(negedge clk); cyc++;
    end
    check("t4_halted", halted, 1);
    check("t4_pc", pc, 16'd0);
    check("t4_wdata", last_wdata, 16'h0000);
    clear_mon();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); run = ~run;
    end
    check("t4_req_cnt", req_cnt, 0);
    check("t4_still_halted", halted, 1);
    check("t4_pc_hold", pc, 16'd0);
    do_reset();
    #1;
    check("t4_rst_halted", halted, 0);
    check("t4_rst_pc", pc, 16'd0);

    // 5: wait states, branch to 0xFFFE, fetch wraps through 0x0000
    lat = 3;
    load_prog(16'hFFFE, 16'd1, 16'd1);
    poke(16'hFFFE, 16'd20);
    poke(16'hFFFF, 16'd21);
    poke(16'd20, 16'd1);
    poke(16'd21, 16'd5);
    clear_mon();
    @(negedge clk); run = 1'b1;
    wait_pc_change(100, cyc);
    check("t5_pc_branch", pc, 16'hFFFE);
    wait_pc_change(100, cyc);
    check("t5_pc_next", pc, 16'h0001);
    check("t5_rd_cnt", rd_log.size(), 10);
    check("t5_fetch_a", rd_log[5], 16'hFFFE);
    check("t5_fetch_b", rd_log[7], 16'hFFFF);
    check("t5_fetch_c", rd_log[9], 16'h0000);
    check("t5_rd_mb", rd_log[8], 16'd21);
    check("t5_aset_cnt", aset_cnt, 2);
    check("t5_stable", stab_err, 0);
    check("t5_waddr", last_waddr, 16'd21);
    check("t5_wdata", last_wdata, 16'h0004);

    // 6: reset while the write is waiting for ack
    do_reset();
    load_prog(16'd9, 16'd5, 16'd7);
    @(negedge clk); run = 1'b1;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_req && mem_we) begin
        found = 1;
        break;
      end
    end
    check("t6_reached_wr", found, 1);
    areset = 1'b1; run = 1'b0;
    @(posedge clk); #1;
    check("t6_req", mem_req, 0);
    check("t6_pc", pc, 16'd0);
    @(negedge clk); areset = 1'b0;
    clear_mon();
    repeat (10) @(negedge clk);
    check("t6_idle_req", req_cnt, 0);
    check("t6_no_write", mem[11], 16'd7);
    check("t6_halted", halted, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
